menu_button_conditioner: RTL and testbench

- Front-end conditioner for the three menu buttons: up, down and confirm.
- Each raw board input is synchronised, debounced and converted into single-cycle press pulses. Up and down also get a hold-to-repeat pulse train.
- The pulses drive the menu selection stage directly. That stage acts on every cycle a button input is high, so its inputs must be exactly one cycle wide per intended step.

---
 rtl/menu_button_conditioner.sv | 187 ++++++++++++++++++
 tb/tb_menu_button_conditioner.sv | 131 +++++++++++++
 2 files changed

// File: rtl/menu_button_conditioner.sv
// Menu button front end: synchronise, debounce and pulse-convert up/down/confirm,
// with hold-to-repeat on up/down and one-pulse-per-cycle arbitration.

module menu_btn_debounce #(
    parameter int unsigned DB_CYCLES = 1000000,
    parameter int unsigned DB_WIDTH  = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    logic                s1;
    logic                s2;
    logic [DB_WIDTH-1:0] cnt;
    logic                cnt_done;

    assign cnt_done = (cnt == DB_WIDTH'(DB_CYCLES - 1));
    // Asserted in the cycle whose closing edge flips the level 0->1, so the
    // registered pulse downstream lands right after that edge.
    assign rise     = s2 & ~level & cnt_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt_done) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DB_WIDTH'(1);
            end
        end
    end
endmodule

module menu_btn_repeat #(
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 20000000,
    parameter int unsigned RPT_WIDTH    = 26,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic level,
    input  logic rise,
    output logic rpt
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RPT  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [RPT_WIDTH-1:0] hold;
    logic [RPT_WIDTH-1:0] hold_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            hold  <= '0;
        end else begin
            state <= state_n;
            hold  <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold;
        rpt     = 1'b0;
        if (!REPEAT_EN) begin
            state_n = S_IDLE;
            hold_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    hold_n = '0;
                    if (rise) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (!level) begin
                        state_n = S_IDLE;
                        hold_n  = '0;
                    end else if (hold == RPT_WIDTH'(REPEAT_DELAY - 1)) begin
                        rpt     = 1'b1;
                        hold_n  = '0;
                        state_n = S_RPT;
                    end else begin
                        hold_n = hold + RPT_WIDTH'(1);
                    end
                end
                S_RPT: begin
                    if (!level) begin
                        state_n = S_IDLE;
                        hold_n  = '0;
                    end else if (hold == RPT_WIDTH'(REPEAT_RATE - 1)) begin
                        rpt    = 1'b1;
                        hold_n = '0;
                    end else begin
                        hold_n = hold + RPT_WIDTH'(1);
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    hold_n  = '0;
                end
            endcase
        end
    end
endmodule

module menu_button_conditioner #(
    parameter int unsigned DB_CYCLES    = 1000000,
    parameter int unsigned DB_WIDTH     = 20,
    parameter int unsigned REPEAT_DELAY = 50000000,
    parameter int unsigned REPEAT_RATE  = 20000000,
    parameter int unsigned RPT_WIDTH    = 26,
    parameter bit          REPEAT_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_raw,
    input  logic       down_raw,
    input  logic       confirm_raw,
    output logic       up_pulse,
    output logic       down_pulse,
    output logic       confirm_pulse,
    output logic [2:0] btn_level
);
    logic up_level, down_level, confirm_level;
    logic up_rise, down_rise, confirm_rise;
    logic up_rpt, down_rpt;
    logic up_req, down_req;

    menu_btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_up (
        .clk(clk), .reset(reset), .raw(up_raw), .level(up_level), .rise(up_rise)
    );
    menu_btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_down (
        .clk(clk), .reset(reset), .raw(down_raw), .level(down_level), .rise(down_rise)
    );
    menu_btn_debounce #(.DB_CYCLES(DB_CYCLES), .DB_WIDTH(DB_WIDTH)) u_db_confirm (
        .clk(clk), .reset(reset), .raw(confirm_raw), .level(confirm_level),
        .rise(confirm_rise)
    );

    menu_btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE),
        .RPT_WIDTH(RPT_WIDTH), .REPEAT_EN(REPEAT_EN)
    ) u_rpt_up (
        .clk(clk), .reset(reset), .level(up_level), .rise(up_rise), .rpt(up_rpt)
    );
    menu_btn_repeat #(
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE),
        .RPT_WIDTH(RPT_WIDTH), .REPEAT_EN(REPEAT_EN)
    ) u_rpt_down (
        .clk(clk), .reset(reset), .level(down_level), .rise(down_rise), .rpt(down_rpt)
    );

    assign up_req   = up_rise | up_rpt;
    assign down_req = down_rise | down_rpt;

    // Losing requests are dropped: the selection stage steps once per high cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            up_pulse      <= 1'b0;
            down_pulse    <= 1'b0;
            confirm_pulse <= 1'b0;
        end else begin
            up_pulse      <= up_req;
            down_pulse    <= down_req & ~up_req;
            confirm_pulse <= confirm_rise & ~up_req & ~down_req;
        end
    end

    assign btn_level = {confirm_level, down_level, up_level};
endmodule

// File: tb/tb_menu_button_conditioner.sv
// Directed bench for menu_button_conditioner with short debounce/repeat timings.

module tb_menu_button_conditioner;
    logic       clk;
    logic       reset;
    logic       up_raw;
    logic       down_raw;
    logic       confirm_raw;
    logic       up_pulse;
    logic       down_pulse;
    logic       confirm_pulse;
    logic [2:0] btn_level;

    int n_tests = 0;
    int n_fail  = 0;

    menu_button_conditioner #(
        .DB_CYCLES(4), .DB_WIDTH(3),
        .REPEAT_DELAY(10), .REPEAT_RATE(3), .RPT_WIDTH(4), .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk), .reset(reset),
        .up_raw(up_raw), .down_raw(down_raw), .confirm_raw(confirm_raw),
        .up_pulse(up_pulse), .down_pulse(down_pulse), .confirm_pulse(confirm_pulse),
        .btn_level(btn_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic u, input logic d, input logic c, input logic r);
        @(negedge clk);
        up_raw      = u;
        down_raw    = d;
        confirm_raw = c;
        reset       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    function automatic logic [5:0] obs();
        return {btn_level, up_pulse, down_pulse, confirm_pulse};
    endfunction

    function automatic logic [5:0] pack(input logic [2:0] lvl, input logic u, input logic d,
                                        input logic c);
        return {lvl, u, d, c};
    endfunction

    initial begin
        logic       exp_u;
        logic [2:0] exp_l;
        int         cnt;

        up_raw = 1'b0; down_raw = 1'b0; confirm_raw = 1'b0; reset = 1'b1;
        do_reset();
        check("reset_state", 32'(obs()), 32'(6'd0));

        // Up held for edges 0..29: press at 5, repeats every 3 from 15 to 33.
        for (int e = 0; e <= 40; e++) begin
            step(e <= 29, 1'b0, 1'b0, 1'b0);
            exp_u = (e == 5) || (e >= 15 && e <= 33 && ((e - 15) % 3) == 0);
            exp_l = (e >= 5 && e <= 34) ? 3'b001 : 3'b000;
            check($sformatf("up_hold e%0d", e), 32'(obs()), 32'(pack(exp_l, exp_u, 1'b0, 1'b0)));
        end

        // Down bouncing with 2-cycle runs never settles.
        do_reset();
        for (int e = 0; e <= 30; e++) begin
            step(1'b0, (e < 20) && (((e / 2) % 2) == 0), 1'b0, 1'b0);
            check($sformatf("down_bounce e%0d", e), 32'(obs()), 32'(6'd0));
        end

        // Confirm held 40 cycles: one pulse, no repeat.
        do_reset();
        cnt = 0;
        for (int e = 0; e <= 50; e++) begin
            step(1'b0, 1'b0, e < 40, 1'b0);
            if (confirm_pulse) cnt++;
            exp_l = (e >= 5 && e <= 44) ? 3'b100 : 3'b000;
            check($sformatf("confirm_hold e%0d", e), 32'(obs()),
                  32'(pack(exp_l, 1'b0, 1'b0, e == 5)));
        end
        check("confirm_count", 32'(cnt), 32'd1);

        // All three pressed together: up wins every cycle.
        do_reset();
        for (int e = 0; e <= 30; e++) begin
            step(e < 20, e < 20, e < 20, 1'b0);
            if (e < 20) begin
                exp_u = (e == 5) || (e == 15) || (e == 18);
                exp_l = (e >= 5) ? 3'b111 : 3'b000;
                check($sformatf("all_press e%0d", e), 32'(obs()),
                      32'(pack(exp_l, exp_u, 1'b0, 1'b0)));
            end else begin
                check($sformatf("all_press_tail e%0d", e), 32'({down_pulse, confirm_pulse}), 32'd0);
            end
        end

        // Reset in the middle of an up hold: fresh press after a full debounce.
        do_reset();
        for (int e = 0; e <= 31; e++) begin
            step(1'b1, 1'b0, 1'b0, (e == 12) || (e == 13));
            exp_u = (e == 5) || (e == 19) || (e == 29);
            exp_l = ((e >= 5 && e <= 11) || e >= 19) ? 3'b001 : 3'b000;
            check($sformatf("reset_mid e%0d", e), 32'(obs()), 32'(pack(exp_l, exp_u, 1'b0, 1'b0)));
        end

        // Glitch of 3 cycles on up is rejected.
        do_reset();
        for (int e = 0; e <= 12; e++) begin
            step(e < 3, 1'b0, 1'b0, 1'b0);
            check($sformatf("up_glitch e%0d", e), 32'(obs()), 32'(6'd0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
